sdm_demod_ctrl: RTL and testbench

SDM_DEMOD_CTRL -- requirements
Module: sdm_demod_ctrl

---
 rtl/sdm_demod_ctrl.sv | 133 +++++++++++++
 tb/tb_sdm_demod_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdm_demod_ctrl.sv
// Control wrapper around an sdm_demodulator: sequences reset/settle, generates the bit
// strobe and buffers PCM samples in a small FIFO with a sticky overflow flag.
module sdm_demod_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [7:0]   div,
  input  logic [7:0]   settle,
  input  logic         bit_in,
  input  logic         clear_ovf,
  output logic         dm_rst_n,
  output logic         dm_valid_in,
  output logic         dm_din,
  input  logic         dm_valid_out,
  input  logic [W-1:0] dm_dout,
  output logic         pcm_valid,
  input  logic         pcm_ready,
  output logic [W-1:0] pcm_data,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFlush, StSettle, StRun} state_e;

  state_e         state_q;
  logic [7:0]     div_q;
  logic [7:0]     scnt_q;
  logic [7:0]     setcnt_q;
  logic           flush_q;
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   mem_q [DEPTH];

  logic pop, full, push, drop, wr_en, strobe_due, active;

  always_comb begin
    active     = (state_q == StSettle) || (state_q == StRun);
    pop        = pcm_valid && pcm_ready;
    full       = (cnt_q == CW'(DEPTH));
    push       = (state_q == StRun) && dm_valid_out && enable;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    drop       = push && full && !pop;
    wr_en      = push && !drop;
    strobe_due = active && (({1'b0, scnt_q} + 9'd1) == {1'b0, div_q});
  end

  assign pcm_valid = (cnt_q != '0);
  assign pcm_data  = pcm_valid ? mem_q[rd_q] : '0;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= dm_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= 8'd1;
      scnt_q      <= '0;
      setcnt_q    <= '0;
      flush_q     <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      dm_rst_n    <= 1'b0;
      dm_valid_in <= 1'b0;
      dm_din      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;

      if (!enable) begin
        state_q     <= StIdle;
        dm_valid_in <= 1'b0;
        dm_rst_n    <= 1'b1;
        scnt_q      <= '0;
        setcnt_q    <= '0;
        flush_q     <= 1'b0;
        wr_q        <= '0;
        rd_q        <= '0;
        cnt_q       <= '0;
      end else begin
        if (wr_en) wr_q <= wr_q + 1'b1;
        if (pop)   rd_q <= rd_q + 1'b1;
        cnt_q       <= cnt_q + CW'(wr_en) - CW'(pop);
        dm_valid_in <= 1'b0;
        unique case (state_q)
          StIdle: begin
            state_q  <= StFlush;
            dm_rst_n <= 1'b0;
            flush_q  <= 1'b0;
            div_q    <= (div == 8'd0) ? 8'd1 : div;
            setcnt_q <= settle;
            scnt_q   <= '0;
          end
          StFlush: begin
            if (flush_q) begin
              state_q  <= (setcnt_q != 8'd0) ? StSettle : StRun;
              dm_rst_n <= 1'b1;
              scnt_q   <= '0;
            end else begin
              flush_q <= 1'b1;
            end
          end
          StSettle, StRun: begin
            if (strobe_due) begin
              dm_valid_in <= 1'b1;
              dm_din      <= bit_in;
              scnt_q      <= '0;
            end else begin
              scnt_q <= scnt_q + 8'd1;
            end
            // The pulse that exhausts the settle count is itself discarded.
            if (state_q == StSettle && dm_valid_out) begin
              setcnt_q <= setcnt_q - 8'd1;
              if (setcnt_q == 8'd1) state_q <= StRun;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdm_demod_ctrl.sv
// Self-checking bench for sdm_demod_ctrl against a queue-based timeline model.
module tb_sdm_demod_ctrl;
  localparam int W = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, bit_in = 1'b0, clear_ovf = 1'b0;
  logic dm_valid_out = 1'b0, pcm_ready = 1'b0;
  logic [7:0] div = 8'd0, settle = 8'd0;
  logic [W-1:0] dm_dout = '0;
  logic dm_rst_n, dm_valid_in, dm_din, pcm_valid, busy, overflow;
  logic [W-1:0] pcm_data;

  sdm_demod_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div(div), .settle(settle),
    .bit_in(bit_in), .clear_ovf(clear_ovf), .dm_rst_n(dm_rst_n), .dm_valid_in(dm_valid_in),
    .dm_din(dm_din), .dm_valid_out(dm_valid_out), .dm_dout(dm_dout), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .pcm_data(pcm_data), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: m_n counts edges since the start edge; FLUSH spans m_n 0..1.
  bit m_run = 0;
  int m_n = 0, m_div = 1, m_disc = 0;
  logic [W-1:0] q[$];
  bit m_ovf = 0;
  bit m_din = 0;

  function automatic bit exp_strobe();
    return m_run && m_n >= 2 && (m_n - 2) >= m_div && ((m_n - 2) % m_div) == 0;
  endfunction

  function automatic bit exp_rstn();
    return !(m_run && m_n < 2);
  endfunction

  function automatic logic [W-1:0] exp_head();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  function automatic void model_edge();
    bit pop, push, drop;
    pop = (q.size() > 0) && pcm_ready;
    push = 0;
    drop = 0;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_n = 0; m_div = (div == 0) ? 1 : int'(div); m_disc = int'(settle);
      end
    end else if (!enable) begin
      m_run = 0;
      q.delete();
    end else begin
      if (m_n >= 2 && dm_valid_out) begin
        if (m_disc > 0) m_disc--;
        else if (q.size() == DEPTH && !pop) drop = 1;
        else push = 1;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(dm_dout);
      m_n++;
      if (exp_strobe()) m_din = bit_in;
    end
    if (drop) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
  endfunction

  function automatic void model_reset();
    m_run = 0; q.delete(); m_ovf = 0; m_din = 0; m_n = 0;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] d, input logic [7:0] s);
    enable = 1'b1; div = d; settle = s;
    step(); step(); step();
  endtask

  task automatic stop();
    enable = 1'b0; dm_valid_out = 1'b0; pcm_ready = 1'b0; clear_ovf = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({dm_rst_n, dm_valid_in, dm_din, pcm_valid, busy, overflow} !== 6'b0 || pcm_data !== '0) begin
      errs++;
      $display("FAIL reset_values got %b data=%h expected 000000 data=0",
               {dm_rst_n, dm_valid_in, dm_din, pcm_valid, busy, overflow}, pcm_data);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    vecs++;
    if (dm_rst_n !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release dm_rst_n=%b busy=%b expected 1 0", dm_rst_n, busy);
    end
  endtask

  task automatic test_strobe();
    logic [7:0] divs [5] = '{8'd4, 8'd0, 8'd1, 8'd3, 8'd7};
    for (int k = 0; k < 5; k++) begin
      enable = 1'b1; div = divs[k]; settle = 8'd0; bit_in = 1'($urandom);
      step();
      for (int c = 0; c < 3 * int'(m_div) + 10; c++) begin
        vecs++;
        if (dm_rst_n !== exp_rstn() || dm_valid_in !== exp_strobe() || dm_din !== m_din
            || busy !== 1'b1) begin
          errs++;
          $display("FAIL strobe div=%0d n=%0d rstn/vin/din/busy=%b%b%b%b expected %b%b%b1",
                   divs[k], m_n, dm_rst_n, dm_valid_in, dm_din, busy,
                   exp_rstn(), exp_strobe(), m_din);
        end
        bit_in = 1'($urandom);
        step();
      end
      stop();
      vecs++;
      if (busy !== 1'b0 || dm_valid_in !== 1'b0 || dm_rst_n !== 1'b1) begin
        errs++;
        $display("FAIL strobe_stop busy/vin/rstn=%b%b%b expected 001", busy, dm_valid_in, dm_rst_n);
      end
    end
  endtask

  task automatic test_div0_pattern();
    logic [7:0] pat = 8'b1000_0000;
    enable = 1'b1; div = 8'd0; settle = 8'd0;
    step(); step(); step();
    for (int i = 0; i < 8; i++) begin
      bit_in = pat[7-i];
      step();
      vecs++;
      if (dm_valid_in !== 1'b1 || dm_din !== pat[7-i]) begin
        errs++;
        $display("FAIL div0_pattern bit=%0d vin=%b din=%b expected 1 %b",
                 i, dm_valid_in, dm_din, pat[7-i]);
      end
    end
    stop();
  endtask

  task automatic test_settle();
    pcm_ready = 1'b0;
    start(8'd2, 8'd3);
    for (int v = 1; v <= 5; v++) begin
      dm_valid_out = 1'b1; dm_dout = W'(v);
      step();
      dm_valid_out = 1'b0;
      step();
    end
    pcm_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (pcm_valid !== 1'b1 || pcm_data !== W'(4 + k)) begin
        errs++;
        $display("FAIL settle_out idx=%0d valid=%b data=%0d expected 1 %0d",
                 k, pcm_valid, pcm_data, 4 + k);
      end
      step();
    end
    vecs++;
    if (pcm_valid !== 1'b0) begin
      errs++;
      $display("FAIL settle_empty valid=%b expected 0", pcm_valid);
    end
    stop();
    // Randomised settle count and stream.
    for (int r = 0; r < 4; r++) begin
      start(8'($urandom_range(0, 3)), 8'($urandom_range(0, 4)));
      for (int c = 0; c < 40; c++) begin
        dm_valid_out = ($urandom_range(0, 2) == 0);
        dm_dout = W'($urandom);
        pcm_ready = ($urandom_range(0, 1) == 0);
        step();
        vecs++;
        if (pcm_valid !== (q.size() > 0) || pcm_data !== exp_head()) begin
          errs++;
          $display("FAIL settle_rand c=%0d valid=%b data=%h expected %b %h",
                   c, pcm_valid, pcm_data, q.size() > 0, exp_head());
        end
      end
      stop();
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_drain [4] = '{16'hA1, 16'hA2, 16'hA3, 16'hB0};
    pcm_ready = 1'b0; clear_ovf = 1'b1;
    start(8'd3, 8'd0);
    clear_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dm_valid_out = 1'b1; dm_dout = W'(16'hA0 + i);
      step();
    end
    dm_valid_out = 1'b0;
    vecs++;
    if (overflow !== 1'b1 || pcm_data !== 16'hA0) begin
      errs++;
      $display("FAIL ovf_set ovf=%b head=%h expected 1 a0", overflow, pcm_data);
    end
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clear ovf=%b expected 0", overflow);
    end
    dm_valid_out = 1'b1; dm_dout = 16'hB0; pcm_ready = 1'b1;
    step();
    dm_valid_out = 1'b0; pcm_ready = 1'b0;
    vecs++;
    if (overflow !== 1'b0 || pcm_data !== 16'hA1) begin
      errs++;
      $display("FAIL full_push_pop ovf=%b head=%h expected 0 a1", overflow, pcm_data);
    end
    pcm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (pcm_valid !== 1'b1 || pcm_data !== exp_drain[k]) begin
        errs++;
        $display("FAIL drain idx=%0d valid=%b data=%h expected 1 %h",
                 k, pcm_valid, pcm_data, exp_drain[k]);
      end
      step();
    end
    vecs++;
    if (pcm_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain_empty valid=%b expected 0", pcm_valid);
    end
    // Drop coinciding with clear_ovf keeps the flag set.
    pcm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dm_valid_out = 1'b1; dm_dout = W'(i); clear_ovf = (i == 4);
      step();
    end
    dm_valid_out = 1'b0; clear_ovf = 1'b0;
    vecs++;
    if (overflow !== 1'b1) begin
      errs++;
      $display("FAIL drop_vs_clear ovf=%b expected 1", overflow);
    end
    stop();
  endtask

  task automatic test_enable_drop();
    bit prior;
    pcm_ready = 1'b0;
    start(8'd2, 8'd0);
    for (int i = 0; i < 2; i++) begin
      dm_valid_out = 1'b1; dm_dout = W'(16'h50 + i);
      step();
    end
    dm_valid_out = 1'b0;
    prior = m_ovf;
    vecs++;
    if (pcm_valid !== 1'b1) begin
      errs++;
      $display("FAIL queued_before_drop valid=%b expected 1", pcm_valid);
    end
    stop();
    vecs++;
    if (busy !== 1'b0 || pcm_valid !== 1'b0 || dm_valid_in !== 1'b0 || overflow !== prior) begin
      errs++;
      $display("FAIL enable_drop busy/valid/vin/ovf=%b%b%b%b expected 000%b",
               busy, pcm_valid, dm_valid_in, overflow, prior);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      enable = ($urandom_range(0, 39) != 0);
      div = 8'($urandom_range(0, 4));
      settle = 8'($urandom_range(0, 3));
      bit_in = 1'($urandom);
      dm_valid_out = ($urandom_range(0, 2) == 0);
      dm_dout = W'($urandom);
      pcm_ready = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 19) == 0);
      step();
      vecs++;
      if (dm_rst_n !== exp_rstn() || dm_valid_in !== exp_strobe() || dm_din !== m_din
          || busy !== m_run || pcm_valid !== (q.size() > 0) || pcm_data !== exp_head()
          || overflow !== m_ovf) begin
        errs++;
        $display("FAIL random c=%0d rstn/vin/din/busy/valid/ovf=%b%b%b%b%b%b data=%h expected %b%b%b%b%b%b %h",
                 c, dm_rst_n, dm_valid_in, dm_din, busy, pcm_valid, overflow, pcm_data,
                 exp_rstn(), exp_strobe(), m_din, m_run, q.size() > 0, m_ovf, exp_head());
      end
    end
    stop();
  endtask

  task automatic test_async_reset();
    pcm_ready = 1'b0;
    start(8'd1, 8'd0);
    for (int i = 0; i < 2; i++) begin
      dm_valid_out = 1'b1; dm_dout = W'(16'h77 + i); bit_in = 1'b1;
      step();
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if ({dm_rst_n, dm_valid_in, dm_din, pcm_valid, busy, overflow} !== 6'b0 || pcm_data !== '0) begin
      errs++;
      $display("FAIL async_reset got %b data=%h expected 000000 data=0",
               {dm_rst_n, dm_valid_in, dm_din, pcm_valid, busy, overflow}, pcm_data);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (dm_valid_in !== 1'b0 || pcm_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_hold vin/valid/busy=%b%b%b expected 000",
               dm_valid_in, pcm_valid, busy);
    end
    enable = 1'b0; dm_valid_out = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    vecs++;
    if (dm_rst_n !== 1'b1) begin
      errs++;
      $display("FAIL async_release dm_rst_n=%b expected 1", dm_rst_n);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_strobe();
    test_div0_pattern();
    test_settle();
    test_overflow();
    test_enable_drop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
